// File: rtl/spi_input_conditioner.sv
//==============================================================================
// Module  : spi_input_conditioner
// Brief   : 2-flop sync + debounce filter with edge strobes for MOSI/SCLK/CS.
//           Optional glitch counter enabled by INPUTCONDITIONER_GLITCH_CNT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_input_conditioner #(
  parameter int                  CHANNELS  = 3,
  parameter int                  WAIT_TIME = 3,
  parameter logic [CHANNELS-1:0] RESET_VAL = 3'b100
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisysignal,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  input  logic                glitch_clr,
  output logic [7:0]          glitch_count
);

  localparam int             c_cnt_w    = $clog2(WAIT_TIME + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_TIME - 1);

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= noisysignal;
      r_sync2 <= r_sync1;
    end
  end

`ifdef INPUTCONDITIONER_GLITCH_CNT_EN
  logic [CHANNELS-1:0] w_glitch_ev;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_cond;
    logic               r_pos;
    logic               r_neg;

    // Any disagreement that does not persist for WAIT_TIME cycles is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt  <= '0;
        r_cond <= RESET_VAL[gi];
        r_pos  <= 1'b0;
        r_neg  <= 1'b0;
      end else begin
        r_pos <= 1'b0;
        r_neg <= 1'b0;
        if (r_sync2[gi] == r_cond) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_cond <= r_sync2[gi];
          r_cnt  <= '0;
          r_pos  <= r_sync2[gi];
          r_neg  <= ~r_sync2[gi];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign conditioned[gi]  = r_cond;
    assign positiveedge[gi] = r_pos;
    assign negativeedge[gi] = r_neg;

`ifdef INPUTCONDITIONER_GLITCH_CNT_EN
    assign w_glitch_ev[gi] = (r_cnt != '0) && (r_sync2[gi] == r_cond);
`endif
  end

`ifdef INPUTCONDITIONER_GLITCH_CNT_EN
  logic [7:0] r_glitch_count;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_glitch_count <= 8'h00;
    end else if (glitch_clr) begin
      r_glitch_count <= 8'h00;
    end else if ((|w_glitch_ev) && (r_glitch_count != 8'hFF)) begin
      r_glitch_count <= r_glitch_count + 8'h01;
    end
  end

  assign glitch_count = r_glitch_count;
`else
  logic w_unused_glitch_clr;
  assign w_unused_glitch_clr = glitch_clr;
  assign glitch_count        = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_input_conditioner.sv
//==============================================================================
// Module  : tb_spi_input_conditioner
// Brief   : Directed self-checking bench for spi_input_conditioner.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_input_conditioner;

`ifdef INPUTCONDITIONER_GLITCH_CNT_EN
  localparam bit c_gc_en = 1'b1;
`else
  localparam bit c_gc_en = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [2:0] noisysignal;
  logic [2:0] conditioned;
  logic [2:0] positiveedge;
  logic [2:0] negativeedge;
  logic       glitch_clr;
  logic [7:0] glitch_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] r_seen;

  spi_input_conditioner dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .noisysignal  (noisysignal),
    .conditioned  (conditioned),
    .positiveedge (positiveedge),
    .negativeedge (negativeedge),
    .glitch_clr   (glitch_clr),
    .glitch_count (glitch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky record of any edge strobe, sampled mid-cycle.
  always @(negedge clk) r_seen = r_seen | positiveedge | negativeedge;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] gexp(input logic [7:0] v);
    return c_gc_en ? v : 8'h00;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    r_seen      = 3'b000;
    reset_n     = 1'b0;
    glitch_clr  = 1'b0;
    noisysignal = 3'b011;

    // Reset state
    tick(3);
    check("rst_cond", {5'd0, conditioned}, 8'h04);
    check("rst_pos", {5'd0, positiveedge}, 8'h00);
    check("rst_neg", {5'd0, negativeedge}, 8'h00);
    check("rst_gcnt", glitch_count, 8'h00);

    // Release: 011 accepted on edge 5
    reset_n = 1'b1;
    tick(4);
    check("rel_e4_cond", {5'd0, conditioned}, 8'h04);
    tick(1);
    check("rel_e5_cond", {5'd0, conditioned}, 8'h03);
    check("rel_e5_pos", {5'd0, positiveedge}, 8'h03);
    check("rel_e5_neg", {5'd0, negativeedge}, 8'h04);
    tick(1);
    check("rel_e6_pos", {5'd0, positiveedge}, 8'h00);
    check("rel_e6_neg", {5'd0, negativeedge}, 8'h00);

    // Clean SCLK rise
    noisysignal = 3'b001;
    tick(8);
    check("cr_pre_cond", {5'd0, conditioned}, 8'h01);
    noisysignal = 3'b011;
    tick(4);
    check("cr_e4_cond", {5'd0, conditioned}, 8'h01);
    check("cr_e4_pos", {5'd0, positiveedge}, 8'h00);
    tick(1);
    check("cr_e5_cond", {5'd0, conditioned}, 8'h03);
    check("cr_e5_pos", {5'd0, positiveedge}, 8'h02);
    check("cr_e5_neg", {5'd0, negativeedge}, 8'h00);
    tick(1);
    check("cr_e6_pos", {5'd0, positiveedge}, 8'h00);
    tick(4);
    check("cr_hold_cond", {5'd0, conditioned}, 8'h03);
    check("cr_gcnt", glitch_count, 8'h00);

    // Single 2-cycle glitch on SCLK
    noisysignal = 3'b001;
    tick(8);
    r_seen = 3'b000;
    noisysignal = 3'b011;
    tick(2);
    noisysignal = 3'b001;
    tick(5);
    check("gl1_cond", {5'd0, conditioned}, 8'h01);
    check("gl1_seen", {5'd0, r_seen}, 8'h00);
    check("gl1_gcnt", glitch_count, gexp(8'h01));

    // 299 more glitches saturate the counter
    for (int g = 0; g < 299; g++) begin
      noisysignal = 3'b011;
      tick(2);
      noisysignal = 3'b001;
      tick(4);
    end
    tick(2);
    check("gl300_cond", {5'd0, conditioned}, 8'h01);
    check("gl300_seen", {5'd0, r_seen}, 8'h00);
    check("gl300_gcnt", glitch_count, gexp(8'hFF));

    // Clear in the same cycle as a glitch event
    noisysignal = 3'b011;
    tick(2);
    noisysignal = 3'b001;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    check("clr_gcnt", glitch_count, 8'h00);
    tick(3);
    check("clr_after_gcnt", glitch_count, 8'h00);

    // Simultaneous MOSI rise and CS fall
    noisysignal = 3'b100;
    tick(8);
    check("sim_pre_cond", {5'd0, conditioned}, 8'h04);
    noisysignal = 3'b001;
    tick(4);
    check("sim_e4_pos", {5'd0, positiveedge}, 8'h00);
    tick(1);
    check("sim_e5_cond", {5'd0, conditioned}, 8'h01);
    check("sim_e5_pos", {5'd0, positiveedge}, 8'h01);
    check("sim_e5_neg", {5'd0, negativeedge}, 8'h04);
    tick(1);
    check("sim_e6_pos", {5'd0, positiveedge}, 8'h00);
    check("sim_e6_neg", {5'd0, negativeedge}, 8'h00);

    // Reset in the middle of an SCLK count
    noisysignal = 3'b011;
    tick(3);
    reset_n = 1'b0;
    #1;
    r_seen = 3'b000;
    check("mr_cond", {5'd0, conditioned}, 8'h04);
    check("mr_pos", {5'd0, positiveedge}, 8'h00);
    check("mr_gcnt", glitch_count, 8'h00);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    check("mr_e4_cond", {5'd0, conditioned}, 8'h04);
    check("mr_e4_seen", {5'd0, r_seen}, 8'h00);
    tick(1);
    check("mr_e5_cond", {5'd0, conditioned}, 8'h03);
    check("mr_e5_pos", {5'd0, positiveedge}, 8'h03);
    check("mr_e5_neg", {5'd0, negativeedge}, 8'h04);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
